// File: rtl/prog_loader.sv
// Boot loader: packs a big-endian byte stream into 32-bit words, writes them to
// instruction memory from address 0 upward, and holds the CPU in reset until done.
module prog_loader #(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    input  logic                  byte_last,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-2:0] word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    // Highest word-aligned address; writing here means memory is full.
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    state_t                state_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [23:0]           word_reg;
    logic [1:0]            idx_reg;
    logic                  last_flag_reg;
    logic                  byte_ready_reg;
    logic                  mem_we_reg;
    logic [ADDR_WIDTH-1:0] mem_addr_reg;
    logic [31:0]           mem_wdata_reg;
    logic                  cpu_hold_reg;
    logic                  done_reg;
    logic                  error_reg;
    logic [ADDR_WIDTH-2:0] word_count_reg;

    logic [31:0] word_next;
    logic        restart;

    assign word_next = {word_reg, byte_data};
    assign restart   = start && (state_reg == S_IDLE || state_reg == S_DONE || state_reg == S_ERR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            addr_reg       <= '0;
            word_reg       <= '0;
            idx_reg        <= '0;
            last_flag_reg  <= 1'b0;
            byte_ready_reg <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            cpu_hold_reg   <= 1'b1;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
            word_count_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE, S_ERR: begin
                    if (restart) begin
                        state_reg      <= S_LOAD;
                        addr_reg       <= '0;
                        idx_reg        <= '0;
                        word_count_reg <= '0;
                        byte_ready_reg <= 1'b1;
                        cpu_hold_reg   <= 1'b1;
                        done_reg       <= 1'b0;
                        error_reg      <= 1'b0;
                    end
                end
                S_LOAD: begin
                    // byte_ready is always high here, so byte_valid alone means acceptance.
                    if (byte_valid) begin
                        word_reg <= word_next[23:0];
                        idx_reg  <= idx_reg + 2'd1;
                        if (idx_reg == 2'd3) begin
                            state_reg      <= S_WRITE;
                            last_flag_reg  <= byte_last;
                            byte_ready_reg <= 1'b0;
                            mem_we_reg     <= 1'b1;
                            mem_addr_reg   <= addr_reg;
                            mem_wdata_reg  <= word_next;
                        end else if (byte_last) begin
                            state_reg      <= S_ERR;
                            byte_ready_reg <= 1'b0;
                            error_reg      <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    mem_we_reg     <= 1'b0;
                    addr_reg       <= addr_reg + ADDR_WIDTH'(4);
                    word_count_reg <= word_count_reg + (ADDR_WIDTH-1)'(1);
                    if (last_flag_reg) begin
                        state_reg    <= S_DONE;
                        done_reg     <= 1'b1;
                        cpu_hold_reg <= 1'b0;
                    end else if (addr_reg == LAST_ADDR) begin
                        state_reg <= S_ERR;
                        error_reg <= 1'b1;
                    end else begin
                        state_reg      <= S_LOAD;
                        byte_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign byte_ready = byte_ready_reg;
    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign cpu_hold   = cpu_hold_reg;
    assign done       = done_reg;
    assign error      = error_reg;
    assign word_count = word_count_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: randomized byte streams into two instances (ADDR_WIDTH 9 and 4),
// expected writes queued by a reference model and checked by an independent monitor.
module tb_prog_loader;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        start_s[2];
    logic        bv[2];
    logic        bl[2];
    logic [7:0]  bd[2];
    logic        o_br[2];
    logic        o_we[2];
    logic        o_hold[2];
    logic        o_done[2];
    logic        o_err[2];
    logic [31:0] o_wdata[2];
    logic [8:0]  addr0;
    logic [3:0]  addr1;
    logic [7:0]  wc0;
    logic [2:0]  wc1;

    prog_loader #(.ADDR_WIDTH(9)) dut0 (
        .clk(clk), .reset(reset), .start(start_s[0]), .byte_valid(bv[0]), .byte_data(bd[0]),
        .byte_last(bl[0]), .byte_ready(o_br[0]), .mem_we(o_we[0]), .mem_addr(addr0),
        .mem_wdata(o_wdata[0]), .cpu_hold(o_hold[0]), .done(o_done[0]), .error(o_err[0]),
        .word_count(wc0)
    );

    prog_loader #(.ADDR_WIDTH(4)) dut1 (
        .clk(clk), .reset(reset), .start(start_s[1]), .byte_valid(bv[1]), .byte_data(bd[1]),
        .byte_last(bl[1]), .byte_ready(o_br[1]), .mem_we(o_we[1]), .mem_addr(addr1),
        .mem_wdata(o_wdata[1]), .cpu_hold(o_hold[1]), .done(o_done[1]), .error(o_err[1]),
        .word_count(wc1)
    );

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          fin;   // 0: more follows, 1: load ends in DONE, 2: load ends in ERR
    } wr_t;

    wr_t q0[$];
    wr_t q1[$];
    int  total = 0;
    int  bad = 0;
    int  pend[2] = '{0, 0};
    wr_t e_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] get_addr(input int d);
        return d != 0 ? 32'(addr1) : 32'(addr0);
    endfunction

    function automatic logic [31:0] get_wc(input int d);
        return d != 0 ? 32'(wc1) : 32'(wc0);
    endfunction

    function automatic int qsize(input int d);
        return d != 0 ? q1.size() : q0.size();
    endfunction

    // Reference: every 4th byte completes a big-endian word written at 4*index;
    // a last flag mid-word or filling memory without a last flag ends in error.
    function automatic void model(input int d, input logic [7:0] b[$], input int aw,
                                  output int n_acc, output int words, output int fin);
        logic [31:0] w;
        int cap;
        wr_t e;
        cap = 1 << (aw - 2);
        words = 0;
        fin = 0;
        n_acc = b.size();
        w = 0;
        for (int k = 0; k < b.size(); k++) begin
            w = (w << 8) | 32'(b[k]);
            if (k % 4 == 3) begin
                e.addr = words * 4;
                e.data = w;
                e.fin  = (k == b.size() - 1) ? 1 : ((words + 1 == cap) ? 2 : 0);
                if (d != 0) q1.push_back(e); else q0.push_back(e);
                words++;
                if (e.fin != 0) begin
                    fin = e.fin;
                    n_acc = k + 1;
                    break;
                end
            end else if (k == b.size() - 1) begin
                fin = 2;
                n_acc = k + 1;
                break;
            end
        end
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (pend[d] == 1) begin
                chk("done_after_last_write", o_done[d], 1'b1);
                chk("hold_release_after_last_write", o_hold[d], 1'b0);
            end else if (pend[d] == 2) begin
                chk("err_after_full_write", o_err[d], 1'b1);
                chk("hold_in_err", o_hold[d], 1'b1);
            end
            pend[d] = 0;
            if (!reset && o_we[d]) begin
                chk("ready_low_in_write", o_br[d], 1'b0);
                chk("hold_in_write", o_hold[d], 1'b1);
                if (qsize(d) == 0) begin
                    chk("unexpected_write_addr", get_addr(d), 32'hFFFF_FFFF);
                end else begin
                    if (d != 0) e_m = q1.pop_front(); else e_m = q0.pop_front();
                    chk("write_addr", get_addr(d), e_m.addr);
                    chk("write_data", o_wdata[d], e_m.data);
                    $display("write dut%0d addr=%0h data=%08h", d, get_addr(d), o_wdata[d]);
                    pend[d] = e_m.fin;
                end
            end
        end
    end

    task automatic chk_reset_vals(input int d);
        chk("rst_byte_ready", o_br[d], 1'b0);
        chk("rst_mem_we", o_we[d], 1'b0);
        chk("rst_mem_addr", get_addr(d), 0);
        chk("rst_mem_wdata", o_wdata[d], 0);
        chk("rst_cpu_hold", o_hold[d], 1'b1);
        chk("rst_done", o_done[d], 1'b0);
        chk("rst_error", o_err[d], 1'b0);
        chk("rst_word_count", get_wc(d), 0);
    endtask

    task automatic do_start(input int d);
        @(negedge clk);
        start_s[d] = 1'b1;
        @(negedge clk);
        start_s[d] = 1'b0;
        chk("ready_after_start", o_br[d], 1'b1);
        chk("hold_after_start", o_hold[d], 1'b1);
        chk("done_cleared", o_done[d], 1'b0);
        chk("error_cleared", o_err[d], 1'b0);
    endtask

    // gap: 0 = always valid, 1 = valid every other cycle, 2 = random gaps
    task automatic send(input int d, input logic [7:0] b[$], input int n_send,
                        input int gap, input bit last_en);
        int i = 0;
        int cyc = 0;
        logic tog = 1'b0;
        logic v;
        while (i < n_send && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            v = (gap == 0) ? 1'b1 : (gap == 1) ? tog : 1'($urandom_range(0, 1));
            tog = ~tog;
            bv[d] = v;
            bd[d] = v ? b[i] : 8'($urandom);
            bl[d] = v ? (last_en && i == b.size() - 1) : 1'($urandom_range(0, 1));
            if (v && o_br[d]) i++;
        end
        @(negedge clk);
        bv[d] = 1'b0;
        bl[d] = 1'b0;
        chk("bytes_accepted", i, n_send);
    endtask

    task automatic wait_writes(input int d);
        for (int c = 0; c < 50 && qsize(d) != 0; c++) @(negedge clk);
        chk("writes_pending", qsize(d), 0);
    endtask

    task automatic run_load(input int d, input logic [7:0] b[$], input int gap);
        int n_acc, words, fin;
        model(d, b, (d != 0) ? 4 : 9, n_acc, words, fin);
        do_start(d);
        send(d, b, n_acc, gap, 1'b1);
        wait_writes(d);
        repeat (2) @(negedge clk);
        chk("final_done", o_done[d], fin == 1);
        chk("final_error", o_err[d], fin == 2);
        chk("final_hold", o_hold[d], fin != 1);
        chk("final_ready", o_br[d], 1'b0);
        chk("final_word_count", get_wc(d), words);
        $display("load dut%0d bytes=%0d accepted=%0d words=%0d end=%0d", d, b.size(), n_acc, words, fin);
    endtask

    initial begin
        logic [7:0] plan[$];
        logic [7:0] b[$];
        int n_acc, words, fin, d, n;
        plan = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A};
        for (int k = 0; k < 2; k++) begin
            start_s[k] = 1'b0;
            bv[k] = 1'b0;
            bl[k] = 1'b0;
            bd[k] = 8'h00;
        end
        repeat (2) @(negedge clk);
        chk_reset_vals(0);
        chk_reset_vals(1);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_hold", o_hold[0], 1'b1);
        chk("idle_ready", o_br[0], 1'b0);

        run_load(0, plan, 0);
        run_load(0, plan, 1);
        b = plan[0:5];
        run_load(0, b, 0);

        b = {};
        for (int k = 0; k < 20; k++) b.push_back(8'($urandom));
        run_load(1, b, 0);

        // Abort mid-word with reset, then reload from scratch.
        b = plan[0:6];
        model(0, b, 9, n_acc, words, fin);
        do_start(0);
        send(0, b, 7, 0, 1'b0);
        wait_writes(0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 chk_reset_vals(0);
        chk_reset_vals(1);
        @(negedge clk);
        reset = 1'b0;
        $display("reset abort after 7 bytes");
        b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_load(0, b, 0);
        b = '{8'h12, 8'h34, 8'h56, 8'h78};
        run_load(0, b, 2);

        for (int t = 0; t < 20; t++) begin
            d = $urandom_range(0, 1);
            n = $urandom_range(1, (d != 0) ? 24 : 40);
            b = {};
            for (int k = 0; k < n; k++) b.push_back(8'($urandom));
            run_load(d, b, 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader that sits directly upstream of the multicycle MIPS CPU and its instruction memory. It receives a program as a byte stream through a valid/ready handshake and packs each group of four bytes into a big-endian 32-bit word. It writes each word into instruction memory at consecutive word-aligned addresses starting at 0. It holds the CPU in reset until the whole program has been written, then releases it.

## Interface
Parameters:
- ADDR_WIDTH, 9, byte-address width of instruction memory; capacity is 2^ADDR_WIDTH bytes (default 128 words).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  single-cycle pulse that begins a load; honoured in IDLE, DONE and ERR only.
- byte_valid  input  1  byte_data is valid this cycle.
- byte_data  input  8  next program byte; most-significant byte of each word first.
- byte_last  input  1  qualifies byte_data as the final program byte; sampled only on an accepted byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction-memory write strobe, one cycle per word.
- mem_addr  output  ADDR_WIDTH  byte address of the word being written; always a multiple of 4.
- mem_wdata  output  32  assembled word.
- cpu_hold  output  1  drives the CPU reset; 1 keeps the CPU in reset.
- done  output  1  load completed successfully.
- error  output  1  load aborted.
- word_count  output  ADDR_WIDTH-1  number of words written in the current or last load.

## Operation
- A byte is accepted on a rising edge where byte_valid and byte_ready are both 1.
- States:
  - IDLE: byte_ready=0, cpu_hold=1. On start, go to LOAD and clear the address, byte index and word_count.
  - LOAD: byte_ready=1. Each accepted byte is shifted in: word = {word[23:0], byte_data}, and the 2-bit byte index increments.
    - When the accepted byte is the 4th of the word, go to WRITE and latch last_flag = byte_last.
    - If byte_last is set on the 1st, 2nd or 3rd byte of a word, go to ERR without writing.
  - WRITE: byte_ready=0, mem_we=1, mem_addr=current address, mem_wdata=assembled word. On the next edge the address increments by 4 and word_count by 1.
    - If last_flag is set, go to DONE.
    - Otherwise, if the address just written was 2^ADDR_WIDTH−4 (memory full), go to ERR.
    - Otherwise return to LOAD.
  - DONE: done=1, cpu_hold=0. On start, go to LOAD, with done=0 and cpu_hold=1 from the next cycle.
  - ERR: error=1, cpu_hold=1. On start, go to LOAD and clear error.
- start is ignored in LOAD and WRITE.
- mem_addr and mem_wdata are don't-care when mem_we=0, but hold their last values.
- Address arithmetic is unsigned modulo 2^ADDR_WIDTH. Wrap-around never produces a write, because the overflow case ends in ERR.
- word_count saturates naturally: at most 2^(ADDR_WIDTH−2) words can be written.

## Timing
- Reset values: byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, error=0, word_count=0; state=IDLE.
- byte_ready rises one cycle after start is sampled.
- Latency from acceptance of a word's 4th byte to mem_we high is 1 cycle. mem_we is high for exactly 1 cycle.
- Peak throughput is 4 bytes per 5 cycles, because byte_ready is low during WRITE.
- cpu_hold falls, and done rises, on the edge after the final WRITE cycle.
- Gaps in byte_valid stall the loader indefinitely. There is no timeout.
- Reset asserted mid-operation aborts the load. Outputs return to reset values immediately and asynchronously, and a partial word is discarded. Memory already written is left unchanged.

## Test plan
- Reset, start, then 8 bytes 0x20,0x08,0x00,0x05,0x20,0x09,0x00,0x0A with byte_last on the 8th -> writes 0x20080005@0 and 0x2009000A@4, word_count=2, done=1, cpu_hold=0 one cycle after the 2nd write.
- Same stream with byte_valid toggling every other cycle -> identical writes and addresses. byte_ready is never high during a WRITE cycle.
- byte_last on the 6th byte -> one write (word 0 only), then error=1, cpu_hold=1, no second mem_we.
- ADDR_WIDTH=4, 20 bytes with byte_last on byte 20 -> 4 writes at 0,4,8,12, then ERR after the write at 12, word_count=4, done=0.
- Assert reset after 3 bytes of the 2nd word -> all outputs at reset values in the same cycle with no write. A fresh start plus 4 bytes 0xDEADBEEF with last -> write 0xDEADBEEF@0.
- From DONE, pulse start and load 4 bytes with last -> cpu_hold is 1 from the cycle after start until the new write completes, then releases. word_count=1.
